// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and parity-mode constants used by both the transmit and receive paths.
package uart_pkg;

   localparam int unsigned DEF_WIDTH      = 8;
   localparam int unsigned DEF_OVERSAMPLE = 16;

   localparam int unsigned PAR_EVEN = 0;
   localparam int unsigned PAR_ODD  = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset never looks like a start bit.
module uart_rx_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start-bit validation, LSB-first data capture,
// optional parity check and stop-bit check with a one-cycle valid pulse.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = PAR_EVEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_tick,
   input  logic             rx,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             parity_err,
   output logic             frame_err,
   output logic             busy
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(WIDTH + 1);

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
   localparam logic              PAR_MODE  = 1'(PARITY_ODD);

   logic              w_rx_s;
   rx_state_t         r_state;
   logic [TICK_W-1:0] r_tick;
   logic [BIT_W-1:0]  r_bit;
   logic [WIDTH-1:0]  r_shift;
   logic              r_par_err;
   logic [WIDTH-1:0]  r_data_out;
   logic              r_data_valid;
   logic              r_parity_err;
   logic              r_frame_err;
   logic              r_busy;

   uart_rx_sync #(
      .STAGES (2)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx),
      .o_q (w_rx_s)
   );

   // Frame FSM; counters only move on sample_tick so a stalled tick freezes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_tick       <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_par_err    <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  r_tick    <= '0;
                  r_bit     <= '0;
                  r_par_err <= 1'b0;
                  r_state   <= START;
                  r_busy    <= 1'b1;
               end
            end

            START: begin
               if (sample_tick) begin
                  if (r_tick == TICK_HALF) begin
                     r_tick <= '0;
                     if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= DATA;
                     end
                  end else begin
                     r_tick <= r_tick + TICK_W'(1);
                  end
               end
            end

            DATA: begin
               if (sample_tick) begin
                  if (r_tick == TICK_FULL) begin
                     r_tick  <= '0;
                     r_shift <= {w_rx_s, r_shift[WIDTH-1:1]};
                     if (r_bit == BIT_LAST) begin
                        r_bit   <= '0;
                        r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                     end else begin
                        r_bit <= r_bit + BIT_W'(1);
                     end
                  end else begin
                     r_tick <= r_tick + TICK_W'(1);
                  end
               end
            end

            PARITY: begin
               if (sample_tick) begin
                  if (r_tick == TICK_FULL) begin
                     r_tick    <= '0;
                     r_par_err <= ((^r_shift) ^ w_rx_s) != PAR_MODE;
                     r_state   <= STOP;
                  end else begin
                     r_tick <= r_tick + TICK_W'(1);
                  end
               end
            end

            // Leave at the stop-bit centre so a back-to-back start bit is caught.
            STOP: begin
               if (sample_tick) begin
                  if (r_tick == TICK_FULL) begin
                     r_tick       <= '0;
                     r_data_out   <= r_shift;
                     r_parity_err <= r_par_err;
                     r_frame_err  <= !w_rx_s;
                     r_data_valid <= 1'b1;
                     if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= BREAK_WAIT;
                     end
                  end else begin
                     r_tick <= r_tick + TICK_W'(1);
                  end
               end
            end

            BREAK_WAIT: begin
               if (w_rx_s) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: even-parity, odd-parity and no-parity
// receivers driven with table vectors, corner sequences and random frames.
`timescale 1ns/1ps
module tb_uart_rx_core;

   localparam int unsigned OS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sample_tick = 1'b0;
   logic rx_p = 1'b1;
   logic rx_n = 1'b1;

   logic [7:0] do_e, do_o, do_n;
   logic dv_e, pe_e, fe_e, bz_e;
   logic dv_o, pe_o, fe_o, bz_o;
   logic dv_n, pe_n, fe_n, bz_n;

   int n_checks = 0;
   int n_pass   = 0;

   int unsigned tick_per = 3;
   int unsigned tdiv = 0;

   logic [9:0] obs_e[$];
   logic [9:0] obs_o[$];
   logic [9:0] obs_n[$];

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       stop;
      logic       pe_even;
      logic       pe_odd;
      logic       fe;
   } vec_t;

   vec_t tbl[8];

   uart_rx_core #(.WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx_p),
      .data_out(do_e), .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e), .busy(bz_e));

   uart_rx_core #(.WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx_p),
      .data_out(do_o), .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o), .busy(bz_o));

   uart_rx_core #(.WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx_n),
      .data_out(do_n), .data_valid(dv_n), .parity_err(pe_n), .frame_err(fe_n), .busy(bz_n));

   always #5 clk = ~clk;

   // Oversample tick: one clk high every tick_per clks.
   always @(negedge clk) begin
      tdiv = (tdiv + 1 >= tick_per) ? 0 : tdiv + 1;
      sample_tick = (tdiv == 0);
   end

   // Record every completed frame as {data, parity_err, frame_err}.
   always @(negedge clk) begin
      if (dv_e) obs_e.push_back({do_e, pe_e, fe_e});
      if (dv_o) obs_o.push_back({do_o, pe_o, fe_o});
      if (dv_n) obs_n.push_back({do_n, pe_n, fe_n});
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: bench exceeded time limit, finished %0d of %0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_ticks(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         while (!sample_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) rx_p = v;
      else rx_n = v;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                             input logic p, input logic stop);
      set_rx(sel, 1'b0);
      wait_ticks(OS);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, d[i]);
         wait_ticks(OS);
      end
      if (has_par) begin
         set_rx(sel, p);
         wait_ticks(OS);
      end
      set_rx(sel, stop);
      wait_ticks(OS);
   endtask

   function automatic int obs_size(input int sel);
      case (sel)
         0:       return obs_e.size();
         1:       return obs_o.size();
         default: return obs_n.size();
      endcase
   endfunction

   task automatic expect_rec(input int sel, input string name, input logic [7:0] d,
                             input logic pe, input logic fe);
      logic [9:0] got;
      int sz;
      sz = obs_size(sel);
      check({name, "_present"}, 32'(sz != 0), 32'(1));
      if (sz != 0) begin
         case (sel)
            0:       got = obs_e.pop_front();
            1:       got = obs_o.pop_front();
            default: got = obs_n.pop_front();
         endcase
         check(name, 32'(got), 32'({d, pe, fe}));
      end
   endtask

   task automatic expect_empty(input int sel, input string name);
      check({name, "_no_extra"}, 32'(obs_size(sel)), 32'(0));
   endtask

   initial begin
      logic [7:0] d;
      logic p, stop, odd_ones;
      int gap;
      bit done;

      tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_data_out",   32'(do_e), 32'(0));
      check("rst_data_valid", 32'(dv_e), 32'(0));
      check("rst_flags",      32'({pe_e, fe_e}), 32'(0));
      check("rst_busy",       32'({bz_e, bz_o, bz_n}), 32'(0));
      rst = 1'b0;
      wait_ticks(OS);
      check("idle_busy", 32'({bz_e, bz_o, bz_n}), 32'(0));

      // Table vectors on the parity receivers
      for (int i = 0; i < 8; i++) begin
         send_frame(0, tbl[i].d, 1'b1, tbl[i].p, tbl[i].stop);
         rx_p = 1'b1;
         wait_ticks(OS);
         expect_rec(0, $sformatf("tbl%0d_even", i), tbl[i].d, tbl[i].pe_even, tbl[i].fe);
         expect_rec(1, $sformatf("tbl%0d_odd", i),  tbl[i].d, tbl[i].pe_odd,  tbl[i].fe);
         check($sformatf("tbl%0d_held_flags", i), 32'({pe_e, fe_e, dv_e, bz_e}),
               32'({tbl[i].pe_even, tbl[i].fe, 1'b0, 1'b0}));
      end
      expect_empty(0, "tbl_even");
      expect_empty(1, "tbl_odd");

      // Framing error followed by a break
      send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0);
      wait_ticks(3 * OS);
      check("break_busy", 32'(bz_e), 32'(1));
      expect_rec(0, "break_even", 8'h55, 1'b0, 1'b1);
      expect_rec(1, "break_odd",  8'h55, 1'b1, 1'b1);
      expect_empty(0, "break_even");
      rx_p = 1'b1;
      wait_ticks(OS);
      check("break_release_busy", 32'(bz_e), 32'(0));
      send_frame(0, 8'h12, 1'b1, 1'b0, 1'b1);
      wait_ticks(OS);
      expect_rec(0, "after_break", 8'h12, 1'b0, 1'b0);
      expect_rec(1, "after_break_odd", 8'h12, 1'b1, 1'b0);

      // False start: 4-tick glitch with a tick every clk
      tick_per = 1;
      repeat (4) @(posedge clk);
      #1;
      rx_p = 1'b0;
      wait_ticks(4);
      rx_p = 1'b1;
      check("glitch_busy", 32'(bz_e), 32'(1));
      done = 1'b0;
      for (int k = 0; k <= OS / 2 + 3; k++) begin
         if (!bz_e) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("glitch_busy_clear", 32'(done), 32'(1));
      wait_ticks(OS);
      expect_empty(0, "glitch_even");
      expect_empty(1, "glitch_odd");
      tick_per = 3;
      wait_ticks(2);

      // Back-to-back frames, no parity, no idle gap
      send_frame(1, 8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b1);
      send_frame(1, 8'h81, 1'b0, 1'b0, 1'b1);
      wait_ticks(OS);
      expect_rec(2, "b2b_0", 8'h00, 1'b0, 1'b0);
      expect_rec(2, "b2b_1", 8'hFF, 1'b0, 1'b0);
      expect_rec(2, "b2b_2", 8'h81, 1'b0, 1'b0);
      expect_empty(2, "b2b");

      // Reset during data bit 4 of 0xC3
      d = 8'hC3;
      rx_p = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 4; i++) begin
         rx_p = d[i];
         wait_ticks(OS);
      end
      rx_p = d[4];
      wait_ticks(OS / 2);
      check("mid_busy", 32'(bz_e), 32'(1));
      rst  = 1'b1;
      rx_p = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_data_out", 32'(do_e), 32'(0));
      check("mid_rst_state",    32'({dv_e, pe_e, fe_e, bz_e, bz_o}), 32'(0));
      wait_ticks(2 * OS);
      expect_empty(0, "mid_rst");
      send_frame(0, 8'h7E, 1'b1, 1'b0, 1'b1);
      wait_ticks(OS);
      expect_rec(0, "post_rst", 8'h7E, 1'b0, 1'b0);
      expect_rec(1, "post_rst_odd", 8'h7E, 1'b1, 1'b0);

      // Random frames on the parity receivers against the reference rules
      for (int f = 0; f < 24; f++) begin
         d    = 8'($urandom);
         p    = 1'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         send_frame(0, d, 1'b1, p, stop);
         odd_ones = 1'(($countones(d) + int'(p)) % 2);
         expect_rec(0, $sformatf("rnd%0d_even", f), d, odd_ones,  !stop);
         expect_rec(1, $sformatf("rnd%0d_odd", f),  d, !odd_ones, !stop);
         if (gap > 0) begin
            rx_p = 1'b1;
            wait_ticks(gap * OS);
         end
      end
      rx_p = 1'b1;
      wait_ticks(OS);
      expect_empty(0, "rnd_even");
      expect_empty(1, "rnd_odd");

      // Random frames on the no-parity receiver
      for (int f = 0; f < 8; f++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_frame(1, d, 1'b0, 1'b0, stop);
         expect_rec(2, $sformatf("rndn%0d", f), d, 1'b0, !stop);
         rx_n = 1'b1;
         wait_ticks(OS * $urandom_range(1, 2));
      end
      expect_empty(2, "rndn");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
